exec_ppn_tracker: RTL
=====================

Name: exec_ppn_tracker

Overview:
- Tracks the set of physical pages (PPNs) currently mapped executable on the I-side.
- Answers combinational hit queries for the D-side write guard. The guard blocks any write whose PA hits this set.
- Producer side is the I-side mapping logic, which issues insert and remove requests.
- After LOCK the executable set is monotonic (grow-only), and table overflow fails safe.

Parameters:
- ENTRIES, 8, number of tracked PPN slots (2..32).
- PPN_W, 20, PPN width; equals 32 - PAGE_SHIFT.
- PAGE_SHIFT, 12, log2 of page size.
- REF_W, 4, width of the per-entry reference counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ins_valid  in  1  insert request (PPN became executable).
- ins_ppn  in  PPN_W  PPN to insert.
- ins_ready  out  1  insert accepted when ins_valid && ins_ready.
- rem_valid  in  1  remove request (one executable mapping of the PPN dropped).
- rem_ppn  in  PPN_W  PPN to remove.
- rem_ready  out  1  always 1; removes complete in one cycle.
- flush_req  in  1  single-cycle pulse; clears the table (pre-LOCK only).
- lock_i  in  1  sticky LOCK from the lock controller.
- query_pa  in  32  physical address to check.
- hit_exec_ppn  out  1  query_pa page is executable, or fail-safe is active.
- count  out  $clog2(ENTRIES+1)  number of valid entries.
- err_full  out  1  sticky: an insert was refused because the table was full.
- err_locked_op  out  1  sticky: a remove or flush was attempted while lock_i=1.

Behaviour:
- Reset state: all entries invalid, refcounts 0, count=0, err_full=0, err_locked_op=0. Combinationally this gives hit_exec_ppn=0 and ins_ready=1.
- Entry storage: valid bit, ppn, refcnt[REF_W].
- Query:
  - qppn = query_pa[31:PAGE_SHIFT].
  - hit_exec_ppn = (any valid entry with ppn==qppn) || (lock_i && err_full).
  - Purely combinational, zero latency.
  - Table updates become visible the cycle after acceptance.
- Match and full:
  - ins_match = a valid entry with ppn==ins_ppn.
  - full = (count==ENTRIES).
  - ins_ready = !flush_req && (ins_match || !full).
- Insert (accepted):
  - If ins_match: that entry's refcnt += 1, saturating at all-ones. A saturated entry is pinned and is never decremented or removed, except by flush or rst.
  - Else: allocate the lowest-index invalid slot with refcnt=1; count += 1.
- Refused insert: ins_valid && !ins_ready && !flush_req sets err_full (sticky until rst). The requester holds ins_valid/ins_ppn stable until accepted.
- Remove when lock_i=0:
  - Matching, non-saturated entry with refcnt>1: decrement refcnt.
  - Matching entry with refcnt==1: invalidate the entry; count -= 1.
  - No matching entry: no-op, no error.
- Remove when lock_i=1: the table is unchanged and err_locked_op is set.
- Simultaneous insert and remove, same PPN, entry exists: refcnt unchanged (net zero). No allocation and no invalidation occur.
- Simultaneous insert and remove, same PPN, entry absent: allocate with refcnt=1; the remove is a no-op.
- Simultaneous insert and remove, different PPNs: both are applied.
  - A slot freed by the remove is not reusable by the insert in the same cycle.
  - Full/ins_ready is evaluated on the pre-update table.
- Flush when lock_i=0: all entries are invalidated next cycle and count=0. Flush takes priority; ins_ready=0 that cycle and any remove that cycle is discarded. Sticky errors are not cleared.
- Flush when lock_i=1: ignored; err_locked_op is set.
- lock_i rising mid-operation: takes effect on the same cycle it is sampled high, with no pending state. Once locked, the set only grows.
- Invariant: at most one valid entry per PPN. A duplicate match is a bug; the sim-only assertion fires.
- Invariant: count equals the popcount of the valid bits. Checked by assertion.
- rst while lock_i=1: full clear. Reset overrides the lock; the lock is owned externally.

Test Plan:
- Reset, then insert 0x00080 -> next cycle count=1. query_pa=0x0008_0ABC gives hit=1; query_pa=0x0008_1000 gives hit=0.
- Insert 0x00080 twice, remove once -> still hit, count=1. Second remove -> hit=0, count=0. Remove of absent 0x00123 -> no change, no error.
- ENTRIES=8: fill 0x100..0x107, then insert 0x200 -> ins_ready=0 and err_full=1. Insert 0x103 while full -> accepted (refcnt 2). With lock_i=0, query 0x0030_0000 gives hit=0. Raise lock_i -> hit=1 for any PA.
- lock_i=1 with 0x00080 present: remove 0x00080 and flush_req -> entry retained, hit=1, err_locked_op=1, count unchanged.
- Same-cycle insert and remove of 0x00055 with existing refcnt=1 -> refcnt stays 1, count unchanged. Same-cycle flush and insert -> ins_ready=0, table empty next cycle.
- Insert 0x00AAA sixteen times (REF_W=4) -> refcnt saturates at 15. Sixteen removes -> entry retained, hit=1. Then rst -> count=0, hit=0, all error flags 0.

Source files
------------

// File: rtl/exec_ppn_tracker.sv
// exec_ppn_tracker: set of physical pages currently mapped executable on the
// I-side, with a zero-latency hit query for the D-side write guard.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ins_valid/ins_ppn/ins_ready  insert request (refcounted per PPN)
//   rem_valid/rem_ppn/rem_ready  remove request (always ready)
//   flush_req                  clear the table (ignored once locked)
//   lock_i                     sticky lock; set becomes grow-only
//   query_pa/hit_exec_ppn      combinational page-hit query (fail-safe on overflow)
//   count                      number of valid entries
//   err_full, err_locked_op    sticky error flags
module exec_ppn_tracker #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned PPN_W      = 20,
  parameter int unsigned PAGE_SHIFT = 12,
  parameter int unsigned REF_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ins_valid,
  input  logic [PPN_W-1:0]               ins_ppn,
  output logic                           ins_ready,
  input  logic                           rem_valid,
  input  logic [PPN_W-1:0]               rem_ppn,
  output logic                           rem_ready,
  input  logic                           flush_req,
  input  logic                           lock_i,
  input  logic [31:0]                    query_pa,
  output logic                           hit_exec_ppn,
  output logic [$clog2(ENTRIES+1)-1:0]   count,
  output logic                           err_full,
  output logic                           err_locked_op
);

  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [REF_W-1:0] REF_MAX = '1;
  localparam logic [REF_W-1:0] REF_ONE = REF_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [REF_W-1:0]   ref_q [ENTRIES];

  logic [PPN_W-1:0]   qppn;
  logic [ENTRIES-1:0] ins_hit, rem_hit, q_hit, free_vec, dec_vec;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               ins_match, full, ins_fire, rem_do, flush_do;
  logic               alloc, cancel, inc_en, dec_en;
  logic [CNT_W-1:0]   count_d;
  logic               unused_pa;

  assign qppn      = PPN_W'(query_pa[31:PAGE_SHIFT]);
  assign unused_pa = ^query_pa[PAGE_SHIFT-1:0];

  // CAM compare on all three ports plus lowest free slot search
  always_comb begin
    ins_hit    = '0;
    rem_hit    = '0;
    q_hit      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ins_hit[i] = valid_q[i] && (ppn_q[i] == ins_ppn);
      rem_hit[i] = valid_q[i] && (ppn_q[i] == rem_ppn);
      q_hit[i]   = valid_q[i] && (ppn_q[i] == qppn);
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign ins_match    = |ins_hit;
  assign full         = (count == CNT_W'(ENTRIES));
  assign ins_ready    = !flush_req && (ins_match || !full);
  assign rem_ready    = 1'b1;
  // Overflow after lock means an executable page may be untracked: block everything
  assign hit_exec_ppn = (|q_hit) || (lock_i && err_full);

  assign ins_fire = ins_valid && ins_ready;
  assign flush_do = flush_req && !lock_i;
  assign rem_do   = rem_valid && !lock_i && !flush_req;
  assign alloc    = ins_fire && !ins_match && free_found;
  // Insert and remove of an existing PPN in one cycle cancel out
  assign cancel   = ins_fire && rem_do && ins_match && (ins_ppn == rem_ppn);
  assign inc_en   = ins_fire && ins_match && !cancel;
  assign dec_en   = rem_do && !cancel;

  // Saturated entries are pinned: never decremented nor freed
  always_comb begin
    free_vec = '0;
    dec_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i] = dec_en && rem_hit[i] && (ref_q[i] == REF_ONE) && (ref_q[i] != REF_MAX);
      dec_vec[i]  = dec_en && rem_hit[i] && (ref_q[i] > REF_ONE) && (ref_q[i] != REF_MAX);
    end
  end

  assign count_d = count + CNT_W'(alloc) - CNT_W'(|free_vec);

  // Table and flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      count         <= '0;
      err_full      <= 1'b0;
      err_locked_op <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        ppn_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      if (flush_do) begin
        valid_q <= '0;
        count   <= '0;
        for (int i = 0; i < ENTRIES; i++) ref_q[i] <= '0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (free_vec[i]) begin
            valid_q[i] <= 1'b0;
            ref_q[i]   <= '0;
          end else if (dec_vec[i]) begin
            ref_q[i] <= ref_q[i] - REF_ONE;
          end else if (inc_en && ins_hit[i] && (ref_q[i] != REF_MAX)) begin
            ref_q[i] <= ref_q[i] + REF_ONE;
          end
        end
        if (alloc) begin
          valid_q[free_idx] <= 1'b1;
          ppn_q[free_idx]   <= ins_ppn;
          ref_q[free_idx]   <= REF_ONE;
        end
        count <= count_d;
      end
      if (ins_valid && !ins_ready && !flush_req) err_full <= 1'b1;
      if (lock_i && (rem_valid || flush_req))     err_locked_op <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants: unique PPNs, count tracks valid bits
  always @(posedge clk) begin
    if (!rst) begin
      assert ($countones(valid_q) == int'(count))
        else $error("exec_ppn_tracker: count disagrees with valid bits");
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = i + 1; j < ENTRIES; j++) begin
          assert (!(valid_q[i] && valid_q[j] && (ppn_q[i] == ppn_q[j])))
            else $error("exec_ppn_tracker: duplicate PPN in slots %0d and %0d", i, j);
        end
      end
    end
  end
`endif

endmodule
